// File: rtl/mips_pkg.sv
// Shared core definitions: datapath width, NOP encoding, fetch FSM states.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  // sll $0,$0,0
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold (load low) and squash controls.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            squash_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  output logic            valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o
);

  logic            valid_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4_q;

  // Squash kills the slot but keeps its addresses; otherwise load or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else if (squash_i) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
    end else if (load_i) begin
      valid_q    <= 1'b1;
      instr_q    <= instr_i;
      pc_q       <= pc_i;
      pc_plus4_q <= pc_plus4_i;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory address and
// fills the IF/ID register; handles stall, redirect and halt.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic            halted
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic            load;
  logic            squash;

  assign pc_plus4 = pc_q + XLEN'(4);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: redirect always returns to RUN, halt_req only acts in RUN.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = RUN;
    end else if ((state_q == RUN) && halt_req) begin
      state_d = HALTED;
    end
  end

  // PC update and IF/ID controls in priority redirect > halt > stall > run.
  always_comb begin
    pc_d   = pc_q;
    load   = 1'b0;
    squash = 1'b0;
    if (redirect_valid) begin
      pc_d   = redirect_pc & 32'hFFFF_FFFC;
      squash = 1'b1;
    end else if (state_q == HALTED) begin
      squash = 1'b1;
    end else if (halt_req) begin
      squash = 1'b1;
    end else if (!stall) begin
      pc_d = pc_plus4;
      load = 1'b1;
    end
  end

  // Program counter register; drives the memory address directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .squash_i   (squash),
    .instr_i    (imem_data),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4),
    .valid_o    (if_id_valid),
    .instr_o    (if_id_instr),
    .pc_o       (if_id_pc),
    .pc_plus4_o (if_id_pc_plus4)
  );

  assign imem_addr = pc_q;
  assign halted    = (state_q == HALTED);

endmodule
